// File: rtl/ga_sync_gen.sv
// ---------------------------------------------------------------------------
// ga_sync_gen
//
// Gate-array style sync and raster-interrupt generator. It watches the raw
// CRTC HSYNC/VSYNC waveforms and produces:
//   - a monitor HSYNC of 4 characters, starting 2 characters into the CRTC
//     horizontal sync and cut short if the CRTC sync ends early;
//   - a monitor VSYNC that starts 2 HSYNC falls after the CRTC VSYNC rises
//     and lasts for 4 further HSYNC falls;
//   - the 52-line raster interrupt counter (R52) with VSYNC resynchronisation;
//   - the effective screen mode, latched at the start of monitor HSYNC.
// It reacts only to the sync waveforms and never to CRTC register contents.
//
// Ports
//   CLOCK     in   system clock, all state changes on its rising edge
//   nRESET    in   asynchronous active-low reset
//   CLKEN     in   1 MHz character-clock enable (same as the CRTC counters)
//   HSYNC_I   in   CRTC horizontal sync
//   VSYNC_I   in   CRTC vertical sync
//   INT_ACK   in   CPU interrupt-acknowledge pulse, one CLOCK wide
//   INT_CLR   in   RMR write with bit 4 set, one CLOCK wide
//   MODE_IN   in   [1:0] screen mode last written by the CPU
//   HSYNC_O   out  monitor horizontal sync
//   VSYNC_O   out  monitor vertical sync
//   INT       out  Z80 maskable interrupt request, active-high
//   MODE      out  [1:0] effective screen mode
//   LINE_CNT  out  [5:0] current value of R52
// ---------------------------------------------------------------------------
module ga_sync_gen (
  input  logic       CLOCK,
  input  logic       nRESET,
  input  logic       CLKEN,
  input  logic       HSYNC_I,
  input  logic       VSYNC_I,
  input  logic       INT_ACK,
  input  logic       INT_CLR,
  input  logic [1:0] MODE_IN,
  output logic       HSYNC_O,
  output logic       VSYNC_O,
  output logic       INT,
  output logic [1:0] MODE,
  output logic [5:0] LINE_CNT
);

  // Sync input history, sampled at character rate for edge detection.
  logic       hs_q,    hs_d;
  logic       vs_q,    vs_d;
  // Characters elapsed since the CRTC HSYNC started (saturating).
  logic [3:0] hsc_q,   hsc_d;
  // Monitor HSYNC window (hsc in 2..5), gated by the live HSYNC_I below.
  logic       hwin_q,  hwin_d;
  logic [1:0] mode_q,  mode_d;
  // HSYNC falls still to go before monitor VSYNC starts.
  logic [1:0] vdly_q,  vdly_d;
  logic       vso_q,   vso_d;
  // HSYNC falls left in the current monitor VSYNC.
  logic [2:0] vcnt_q,  vcnt_d;
  logic [5:0] r52_q,   r52_d;
  logic       int_q,   int_d;

  logic       hs_fall_s;
  logic       vs_rise_s;
  logic       vfire_s;
  logic       wrap_s;

  // Next-state logic for every register in the block.
  always_comb begin
    hs_d   = hs_q;
    vs_d   = vs_q;
    hsc_d  = hsc_q;
    hwin_d = hwin_q;
    mode_d = mode_q;
    vdly_d = vdly_q;
    vso_d  = vso_q;
    vcnt_d = vcnt_q;
    r52_d  = r52_q;
    int_d  = int_q;

    // Edges compare the last character-rate sample with the live input.
    hs_fall_s = CLKEN & hs_q & ~HSYNC_I;
    vs_rise_s = CLKEN & VSYNC_I & ~vs_q;
    // The HSYNC fall that ends the vertical delay: frame resync point.
    vfire_s   = hs_fall_s & (vdly_q == 2'd1);
    // Normal 52-line wrap, only when no frame resync happens this line.
    wrap_s    = hs_fall_s & ~vfire_s & (r52_q == 6'd51);

    // --- horizontal ---------------------------------------------------------
    if (CLKEN) begin
      hs_d = HSYNC_I;
      vs_d = VSYNC_I;
      if (!HSYNC_I) begin
        hsc_d = 4'd0;
      end else if (hsc_q != 4'd15) begin
        hsc_d = hsc_q + 4'd1;
      end else begin
        hsc_d = hsc_q;
      end
      hwin_d = (hsc_d >= 4'd2) && (hsc_d <= 4'd5);
      // Mode is only allowed to change as monitor HSYNC begins.
      if (HSYNC_I && (hsc_q == 4'd1)) begin
        mode_d = MODE_IN;
      end else begin
        mode_d = mode_q;
      end
    end else begin
      hs_d   = hs_q;
      vs_d   = vs_q;
      hsc_d  = hsc_q;
      hwin_d = hwin_q;
      mode_d = mode_q;
    end

    // --- vertical delay -----------------------------------------------------
    // A new CRTC VSYNC always restarts the delay, even mid monitor VSYNC.
    if (vs_rise_s) begin
      vdly_d = 2'd2;
    end else if (hs_fall_s && (vdly_q != 2'd0)) begin
      vdly_d = vdly_q - 2'd1;
    end else begin
      vdly_d = vdly_q;
    end

    // --- monitor VSYNC ------------------------------------------------------
    // Fixed length of 4 HSYNC falls; a resync while active does not extend it.
    if (vso_q) begin
      if (hs_fall_s) begin
        if (vcnt_q == 3'd1) begin
          vso_d  = 1'b0;
          vcnt_d = 3'd0;
        end else begin
          vso_d  = 1'b1;
          vcnt_d = vcnt_q - 3'd1;
        end
      end else begin
        vso_d  = vso_q;
        vcnt_d = vcnt_q;
      end
    end else if (vfire_s) begin
      vso_d  = 1'b1;
      vcnt_d = 3'd4;
    end else begin
      vso_d  = vso_q;
      vcnt_d = vcnt_q;
    end

    // --- R52 / interrupt ----------------------------------------------------
    if (INT_CLR) begin
      int_d = 1'b0;
      r52_d = 6'd0;
    end else if (INT_ACK) begin
      // Acknowledge clears bit 5, but a wrap in the same cycle still raises
      // a fresh interrupt and restarts the count.
      if (wrap_s) begin
        int_d = 1'b1;
        r52_d = 6'd0;
      end else begin
        int_d = 1'b0;
        r52_d = r52_q & 6'h1F;
      end
    end else if (vfire_s) begin
      // Resync: fire only if the previous interrupt is at least 32 lines old.
      if (r52_q >= 6'd32) begin
        int_d = 1'b1;
      end else begin
        int_d = int_q;
      end
      r52_d = 6'd0;
    end else if (wrap_s) begin
      int_d = 1'b1;
      r52_d = 6'd0;
    end else if (hs_fall_s) begin
      int_d = int_q;
      r52_d = r52_q + 6'd1;
    end else begin
      int_d = int_q;
      r52_d = r52_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      hsc_q  <= 4'd0;
      hwin_q <= 1'b0;
      mode_q <= 2'd0;
      vdly_q <= 2'd0;
      vso_q  <= 1'b0;
      vcnt_q <= 3'd0;
      r52_q  <= 6'd0;
      int_q  <= 1'b0;
    end else begin
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      hsc_q  <= hsc_d;
      hwin_q <= hwin_d;
      mode_q <= mode_d;
      vdly_q <= vdly_d;
      vso_q  <= vso_d;
      vcnt_q <= vcnt_d;
      r52_q  <= r52_d;
      int_q  <= int_d;
    end
  end

  // HSYNC_O must drop the moment the CRTC sync ends, so the registered
  // window is qualified with the live input.
  assign HSYNC_O  = HSYNC_I & hwin_q;
  assign VSYNC_O  = vso_q;
  assign INT      = int_q;
  assign MODE     = mode_q;
  assign LINE_CNT = r52_q;

endmodule

// File: tb/tb_ga_sync_gen.sv
module tb_ga_sync_gen;

  logic       CLOCK = 1'b0;
  logic       nRESET = 1'b0;
  logic       CLKEN = 1'b0;
  logic       HSYNC_I = 1'b0;
  logic       VSYNC_I = 1'b0;
  logic       INT_ACK = 1'b0;
  logic       INT_CLR = 1'b0;
  logic [1:0] MODE_IN = 2'd0;
  logic       HSYNC_O;
  logic       VSYNC_O;
  logic       INT;
  logic [1:0] MODE;
  logic [5:0] LINE_CNT;

  int total = 0;
  int bad   = 0;

  // values sampled mid-character, just before the CLKEN edge
  logic       s_hso;
  logic [1:0] s_mode;
  logic [5:0] s_line;

  typedef struct {
    logic       hs;
    logic [1:0] mi;
    logic       hso;
    logic [1:0] mode;
    logic [5:0] line;
  } vec_t;

  vec_t tbl[21];

  ga_sync_gen dut (
    .CLOCK(CLOCK), .nRESET(nRESET), .CLKEN(CLKEN),
    .HSYNC_I(HSYNC_I), .VSYNC_I(VSYNC_I),
    .INT_ACK(INT_ACK), .INT_CLR(INT_CLR), .MODE_IN(MODE_IN),
    .HSYNC_O(HSYNC_O), .VSYNC_O(VSYNC_O), .INT(INT),
    .MODE(MODE), .LINE_CNT(LINE_CNT)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One character: an idle clock, then a clock with CLKEN high.
  task automatic tick(input logic hs, input logic vs, input logic ack);
    HSYNC_I = hs;
    VSYNC_I = vs;
    CLKEN   = 1'b0;
    @(posedge CLOCK); #1;
    CLKEN   = 1'b1;
    INT_ACK = ack;
    #1;
    s_hso  = HSYNC_O;
    s_mode = MODE;
    s_line = LINE_CNT;
    @(posedge CLOCK); #1;
    CLKEN   = 1'b0;
    INT_ACK = 1'b0;
  endtask

  // One scan line: HSYNC_I high 2 characters, then low 2 (fall in the 3rd).
  task automatic hline(input logic vs);
    tick(1'b1, vs, 1'b0);
    tick(1'b1, vs, 1'b0);
    tick(1'b0, vs, 1'b0);
    tick(1'b0, vs, 1'b0);
  endtask

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) hline(1'b0);
  endtask

  task automatic ack_pulse();
    INT_ACK = 1'b1;
    @(posedge CLOCK); #1;
    INT_ACK = 1'b0;
  endtask

  task automatic clr_pulse();
    INT_CLR = 1'b1;
    @(posedge CLOCK); #1;
    INT_CLR = 1'b0;
  endtask

  task automatic do_reset();
    HSYNC_I = 1'b0; VSYNC_I = 1'b0; CLKEN = 1'b0;
    INT_ACK = 1'b0; INT_CLR = 1'b0; MODE_IN = 2'd0;
    nRESET = 1'b0;
    @(posedge CLOCK); @(posedge CLOCK); #1;
    nRESET = 1'b1;
  endtask

  initial begin
    int nint;
    //            hs    mi    hso   mode  line
    tbl[0]  = '{1'b1, 2'd2, 1'b0, 2'd0, 6'd0};
    tbl[1]  = '{1'b1, 2'd2, 1'b0, 2'd0, 6'd0};
    tbl[2]  = '{1'b1, 2'd1, 1'b1, 2'd2, 6'd0};
    tbl[3]  = '{1'b1, 2'd1, 1'b1, 2'd2, 6'd0};
    tbl[4]  = '{1'b1, 2'd1, 1'b1, 2'd2, 6'd0};
    tbl[5]  = '{1'b1, 2'd1, 1'b1, 2'd2, 6'd0};
    for (int i = 6; i < 14; i++) tbl[i] = '{1'b1, 2'd1, 1'b0, 2'd2, 6'd0};
    tbl[14] = '{1'b0, 2'd1, 1'b0, 2'd2, 6'd0};
    tbl[15] = '{1'b0, 2'd1, 1'b0, 2'd2, 6'd1};
    // short 3-character pulse
    tbl[16] = '{1'b1, 2'd3, 1'b0, 2'd2, 6'd1};
    tbl[17] = '{1'b1, 2'd3, 1'b0, 2'd2, 6'd1};
    tbl[18] = '{1'b1, 2'd0, 1'b1, 2'd3, 6'd1};
    tbl[19] = '{1'b0, 2'd0, 1'b0, 2'd3, 6'd1};
    tbl[20] = '{1'b0, 2'd0, 1'b0, 2'd3, 6'd2};

    // reset state
    #1;
    chk("rst_hso", HSYNC_O, 0);
    chk("rst_vso", VSYNC_O, 0);
    chk("rst_int", INT, 0);
    chk("rst_mode", MODE, 0);
    chk("rst_line", LINE_CNT, 0);
    do_reset();

    // HSYNC shaping and mode latch, table driven
    for (int i = 0; i < 21; i++) begin
      MODE_IN = tbl[i].mi;
      tick(tbl[i].hs, 1'b0, 1'b0);
      chk($sformatf("vec%0d_hso", i), s_hso, tbl[i].hso);
      chk($sformatf("vec%0d_mode", i), s_mode, tbl[i].mode);
      chk($sformatf("vec%0d_line", i), s_line, tbl[i].line);
    end

    // 312 lines without VSYNC: an interrupt every 52 lines
    do_reset();
    nint = 0;
    for (int i = 1; i <= 312; i++) begin
      hline(1'b0);
      if (i % 52 == 0) begin
        chk("r52_int_set", INT, 1);
        chk("r52_wrap", LINE_CNT, 0);
        if (INT === 1'b1) nint++;
        ack_pulse();
        chk("r52_ack", INT, 0);
      end else begin
        chk("r52_int_idle", INT, 0);
        chk("r52_count", LINE_CNT, i % 52);
      end
    end
    chk("r52_int_total", nint, 6);

    // R52=40 then VSYNC: resync fires an interrupt
    do_reset();
    lines(40);
    chk("v40_line", LINE_CNT, 40);
    hline(1'b1);
    chk("v40_f1_line", LINE_CNT, 41);
    chk("v40_f1_int", INT, 0);
    chk("v40_f1_vso", VSYNC_O, 0);
    hline(1'b1);
    chk("v40_f2_int", INT, 1);
    chk("v40_f2_line", LINE_CNT, 0);
    chk("v40_f2_vso", VSYNC_O, 1);
    ack_pulse();
    chk("v40_ack", INT, 0);
    for (int k = 1; k <= 6; k++) begin
      hline(1'b1);
      chk($sformatf("v40_vso_%0d", k), VSYNC_O, (k < 4) ? 1 : 0);
    end

    // new VSYNC_I rise during VSYNC_O does not extend it
    hline(1'b0);
    hline(1'b1);
    hline(1'b0);
    chk("vre_start", VSYNC_O, 1);
    for (int k = 1; k <= 5; k++) begin
      hline(1'b1);
      chk($sformatf("vre_vso_%0d", k), VSYNC_O, (k < 4) ? 1 : 0);
    end

    // R52=20 then VSYNC: no interrupt, counter restarts
    do_reset();
    lines(20);
    hline(1'b1);
    chk("v20_f1_line", LINE_CNT, 21);
    chk("v20_f1_int", INT, 0);
    hline(1'b1);
    chk("v20_f2_line", LINE_CNT, 0);
    chk("v20_f2_int", INT, 0);

    // INT_CLR at R52=51
    do_reset();
    lines(51);
    chk("clr_pre", LINE_CNT, 51);
    clr_pulse();
    chk("clr_line", LINE_CNT, 0);
    chk("clr_int", INT, 0);

    // INT_ACK clears only bit 5 of R52
    lines(40);
    ack_pulse();
    chk("ack_mask", LINE_CNT, 8);

    // INT_ACK coinciding with the 52-line wrap leaves INT set
    do_reset();
    lines(51);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    chk("ackwrap_int", INT, 1);
    chk("ackwrap_line", LINE_CNT, 0);
    clr_pulse();
    chk("clr_int_set", INT, 0);

    // async reset mid VSYNC_O and mid HSYNC_O
    do_reset();
    hline(1'b1);
    hline(1'b0);
    MODE_IN = 2'd3;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk("mid_hso", HSYNC_O, 1);
    chk("mid_vso", VSYNC_O, 1);
    chk("mid_mode", MODE, 3);
    #2;
    nRESET = 1'b0;
    #1;
    chk("arst_hso", HSYNC_O, 0);
    chk("arst_vso", VSYNC_O, 0);
    chk("arst_mode", MODE, 0);
    chk("arst_line", LINE_CNT, 0);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
